// File: rtl/async_fifo_if.sv
// Producer/consumer bus of the FIFO.
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0, and a
// read is taken when rd_en=1 and empty=0. A taken read presents its word on
// rdata with valid=1 for exactly the following cycle. A request that is not
// taken is dropped, and the matching error pulse (overflow/underflow) is raised
// for one cycle. The bus has no hold or retry semantics.
interface async_fifo_if #(
  parameter int data_width = 8
);
  logic                  wr_en;
  logic [data_width-1:0] wdata;
  logic                  rd_en;
  logic [data_width-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic                  valid;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, full, empty, valid, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, full, empty, valid, overflow, underflow
  );
endinterface

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data, a valid strobe, and
// overflow/underflow pulses. The pointers carry one extra wrap bit, so full and
// empty can be decoded directly from them without a separate counter.
module async_fifo #(
  parameter int data_width   = 8,
  parameter int fifo_depth   = 16,
  parameter int address_size = 5
) (
  input  logic         wr_clk,
  input  logic         rd_clk,
  input  logic         rst,
  async_fifo_if.slave  bus
);
  localparam int idx_w = address_size - 1;

  // rd_clk shares its net with wr_clk, so the design never reads it.
  logic unused_rd_clk;
  assign unused_rd_clk = rd_clk;

  logic [data_width-1:0]   mem_q [fifo_depth];
  logic [address_size-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_size-1:0] rd_ptr_q, rd_ptr_d;
  logic [data_width-1:0]   rdata_q, rdata_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;

  logic [idx_w-1:0] wr_idx, rd_idx;
  logic             full_w, empty_w;
  logic             wr_acc, rd_acc;

  assign wr_idx  = wr_ptr_q[idx_w-1:0];
  assign rd_idx  = rd_ptr_q[idx_w-1:0];
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[address_size-1] != rd_ptr_q[address_size-1]) &&
                   (wr_idx == rd_idx);
  assign wr_acc  = bus.wr_en & ~full_w;
  assign rd_acc  = bus.rd_en & ~empty_w;

  // Next-state: advance the pointers on accepted requests, capture the popped
  // word, and flag any refused requests for the following cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rdata_d     = rdata_q;
    valid_d     = 1'b0;
    overflow_d  = bus.wr_en & full_w;
    underflow_d = bus.rd_en & empty_w;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + address_size'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + address_size'(1);
      rdata_d  = mem_q[rd_idx];
      valid_d  = 1'b1;
    end
  end

  // Pointer and status registers. Reset overrides any request in flight.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write. Memory is not cleared on reset, but no write is taken
  // while reset is high.
  always_ff @(posedge wr_clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_idx] <= bus.wdata;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.valid     = valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo. A queue-based model predicts every output
// after each clock edge, and literal checks pin the model to hand-worked values.
module tb_async_fifo;
  localparam int dw    = 8;
  localparam int depth = 16;

  logic wr_clk = 1'b0;
  logic rd_clk;
  logic rst;

  async_fifo_if #(.data_width(dw)) bus ();

  async_fifo #(.data_width(dw), .fifo_depth(depth), .address_size(5)) dut (
    .wr_clk (wr_clk),
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  // clock / reset
  always #5 wr_clk = ~wr_clk;
  assign rd_clk = wr_clk;

  // model state
  logic [dw-1:0] exp_q[$];
  logic [dw-1:0] m_rdata;
  logic          m_valid, m_ovf, m_unf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    chk("empty",     32'(bus.empty),     32'(exp_q.size() == 0));
    chk("full",      32'(bus.full),      32'(exp_q.size() == depth));
    chk("valid",     32'(bus.valid),     32'(m_valid));
    chk("overflow",  32'(bus.overflow),  32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
    chk("rdata",     32'(bus.rdata),     32'(m_rdata));
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit r, input bit w, input logic [dw-1:0] d, input bit rd);
    bit was_full, was_empty;
    rst       = r;
    bus.wr_en = w;
    bus.wdata = d;
    bus.rd_en = rd;
    was_full  = (exp_q.size() == depth);
    was_empty = (exp_q.size() == 0);
    if (r) begin
      exp_q.delete();
      m_rdata = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_ovf   = w && was_full;
      m_unf   = rd && was_empty;
      m_valid = rd && !was_empty;
      if (m_valid) m_rdata = exp_q.pop_front();
      if (w && !was_full) exp_q.push_back(d);
    end
    @(posedge wr_clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wdata = '0;
    m_rdata = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // 1. reset for two edges
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    chk("lit_rst_empty", 32'(bus.empty), 32'd1);
    chk("lit_rst_full",  32'(bus.full),  32'd0);
    chk("lit_rst_rdata", 32'(bus.rdata), 32'h0);

    // 2. two writes, two reads
    step(0, 1, 8'hA5, 0);
    step(0, 1, 8'h3C, 0);
    step(0, 0, 8'h00, 1);
    chk("lit_t2_rd0", 32'(bus.rdata), 32'hA5);
    chk("lit_t2_v0",  32'(bus.valid), 32'd1);
    step(0, 0, 8'h00, 1);
    chk("lit_t2_rd1", 32'(bus.rdata), 32'h3C);
    chk("lit_t2_emp", 32'(bus.empty), 32'd1);

    // 3. fill to full, then one extra write
    step(0, 1, 8'hFF, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 8'(i), 0);
    chk("lit_t3_full", 32'(bus.full), 32'd1);
    step(0, 1, 8'h0F, 0);
    chk("lit_t3_ovf", 32'(bus.overflow), 32'd1);
    step(0, 0, 8'h00, 0);
    chk("lit_t3_ovf_end", 32'(bus.overflow), 32'd0);

    // 4. drain with two extra reads
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 8'h00, 1);
      if (i == 0)  chk("lit_t4_first", 32'(bus.rdata), 32'hFF);
      if (i == 15) begin
        chk("lit_t4_last",  32'(bus.rdata), 32'h0E);
        chk("lit_t4_empty", 32'(bus.empty), 32'd1);
      end
      if (i == 16) begin
        chk("lit_t4_unf",   32'(bus.underflow), 32'd1);
        chk("lit_t4_novld", 32'(bus.valid),     32'd0);
      end
    end

    // 5. half full, then 10 cycles of simultaneous read/write across the wrap
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'(8'h50 + i), 1);
      if (i == 0) chk("lit_t5_rd0", 32'(bus.rdata), 32'h40);
      if (i == 9) chk("lit_t5_rd9", 32'(bus.rdata), 32'h51);
    end

    // 6. down to 5 words, then reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(1, 1, 8'h77, 1);
    chk("lit_t6_empty", 32'(bus.empty), 32'd1);
    chk("lit_t6_full",  32'(bus.full),  32'd0);
    step(0, 0, 8'h00, 1);
    chk("lit_t6_unf", 32'(bus.underflow), 32'd1);

    // simultaneous read/write at the empty and full boundaries
    step(0, 1, 8'hC1, 1);
    chk("lit_emp_rw_unf", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 15; i++) step(0, 1, 8'(8'hD0 + i), 0);
    step(0, 1, 8'hEE, 1);
    chk("lit_full_rw_ovf", 32'(bus.overflow), 32'd1);
    chk("lit_full_rw_rd",  32'(bus.rdata),    32'hC1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
